// File: rtl/scan_window_addr_gen.sv
// K x K window address generator for the Sobel front end: streams read addresses
// for the first window and then only the incoming column/row, plus one write per centre.
module scan_window_addr_gen #(
   parameter int ADDR_W     = 16,
   parameter int DIM_W      = 12,
   parameter int K          = 3,
   parameter int SERPENTINE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [ADDR_W-1:0] cfg_base_r,
   input  logic [ADDR_W-1:0] cfg_base_w,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [1:0]        direction,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   localparam int H  = (K - 1) / 2;
   localparam int CW = $clog2(K);

   localparam logic [1:0] DIR_NONE  = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [DIM_W-1:0]  H_D      = DIM_W'(H);
   localparam logic [DIM_W-1:0]  K_D      = DIM_W'(K);
   localparam logic [DIM_W-1:0]  HP1_D    = DIM_W'(H + 1);
   localparam logic [DIM_W-1:0]  ONE_D    = DIM_W'(1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] K_A      = ADDR_W'(K);
   localparam logic [ADDR_W-1:0] KM1_A    = ADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0] H_A      = ADDR_W'(H);
   localparam logic [CW-1:0]     LAST_IDX = CW'(K - 1);
   localparam logic [CW-1:0]     ONE_C    = CW'(1);

   typedef enum logic [2:0] {IDLE, PRIME, WRITE, STEP, DONE} state_t;

   state_t             state, next_state;
   logic [DIM_W-1:0]   width_q, height_q, cx, cy;
   logic [ADDR_W-1:0]  width_qa, cfg_width_a, kw_q, kw_in, hw_in;
   logic [ADDR_W-1:0]  win_addr, rd_addr_q, wr_addr_q;
   logic [CW-1:0]      row_i, col_j;
   logic [1:0]         dir_q;
   logic               moving_left;
   logic               rd_fire, wr_fire, start_go, cfg_ok;
   logic               at_row_end, last_pixel;
   logic [DIM_W-1:0]   last_col, last_row;

   assign rd_valid  = (state == PRIME) || (state == STEP);
   assign wr_valid  = (state == WRITE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign rd_addr   = rd_addr_q;
   assign wr_addr   = wr_addr_q;
   assign direction = dir_q;

   assign rd_fire     = rd_valid && rd_ready;
   assign wr_fire     = wr_valid && wr_ready;
   assign start_go    = start && !abort;
   assign cfg_ok      = (cfg_width >= K_D) && (cfg_height >= K_D);
   assign width_qa    = ADDR_W'(width_q);
   assign cfg_width_a = ADDR_W'(cfg_width);
   assign last_col    = width_q - HP1_D;
   assign last_row    = height_q - HP1_D;
   assign at_row_end  = moving_left ? (cx == H_D) : (cx == last_col);
   assign last_pixel  = (cy == last_row) && at_row_end;

   // K*W (down-step row offset) and H*W (first centre row offset) as repeated adds.
   always_comb begin
      kw_in = '0;
      hw_in = '0;
      for (int t = 0; t < K; t++) kw_in = kw_in + cfg_width_a;
      for (int t = 0; t < H; t++) hw_in = hw_in + cfg_width_a;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (state != IDLE && abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:  if (start_go && cfg_ok) next_state = PRIME;
            PRIME: if (rd_fire && row_i == LAST_IDX && col_j == LAST_IDX) next_state = WRITE;
            WRITE: if (wr_fire) begin
                      if (last_pixel)                        next_state = DONE;
                      else if (at_row_end && SERPENTINE == 0) next_state = PRIME;
                      else                                   next_state = STEP;
                   end
            STEP:  if (rd_fire && row_i == LAST_IDX) next_state = WRITE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // win_addr tracks the window's top-left pixel; every new read burst starts from it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         width_q     <= '0;
         height_q    <= '0;
         kw_q        <= '0;
         win_addr    <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         cx          <= '0;
         cy          <= '0;
         moving_left <= 1'b0;
         row_i       <= '0;
         col_j       <= '0;
         dir_q       <= DIR_NONE;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (state == IDLE) begin
            if (start_go) begin
               if (!cfg_ok) begin
                  cfg_err <= 1'b1;
               end else begin
                  width_q     <= cfg_width;
                  height_q    <= cfg_height;
                  kw_q        <= kw_in;
                  win_addr    <= cfg_base_r;
                  rd_addr_q   <= cfg_base_r;
                  wr_addr_q   <= cfg_base_w + hw_in + H_A;
                  cx          <= H_D;
                  cy          <= H_D;
                  moving_left <= 1'b0;
                  row_i       <= '0;
                  col_j       <= '0;
                  dir_q       <= DIR_NONE;
               end
            end
         end else if (abort) begin
            dir_q <= DIR_NONE;
         end else begin
            case (state)
               PRIME: if (rd_fire) begin
                  if (col_j == LAST_IDX) begin
                     col_j     <= '0;
                     row_i     <= (row_i == LAST_IDX) ? '0 : row_i + ONE_C;
                     rd_addr_q <= rd_addr_q + width_qa - KM1_A;
                  end else begin
                     col_j     <= col_j + ONE_C;
                     rd_addr_q <= rd_addr_q + ONE_A;
                  end
               end
               // A raster row restart moves the window from column W-K back to 0 one row
               // lower, which is a net +K on both the window and the centre address.
               WRITE: if (wr_fire) begin
                  if (last_pixel) begin
                     dir_q <= DIR_NONE;
                  end else if (at_row_end && SERPENTINE == 0) begin
                     cx        <= H_D;
                     cy        <= cy + ONE_D;
                     win_addr  <= win_addr + K_A;
                     rd_addr_q <= win_addr + K_A;
                     wr_addr_q <= wr_addr_q + K_A;
                     row_i     <= '0;
                     col_j     <= '0;
                     dir_q     <= DIR_NONE;
                  end else if (at_row_end) begin
                     dir_q       <= DIR_DOWN;
                     rd_addr_q   <= win_addr + kw_q;
                     moving_left <= !moving_left;
                  end else if (moving_left) begin
                     dir_q     <= DIR_LEFT;
                     rd_addr_q <= win_addr - ONE_A;
                  end else begin
                     dir_q     <= DIR_RIGHT;
                     rd_addr_q <= win_addr + K_A;
                  end
               end
               STEP: if (rd_fire) begin
                  if (row_i == LAST_IDX) begin
                     row_i <= '0;
                     case (dir_q)
                        DIR_DOWN: begin
                           cy        <= cy + ONE_D;
                           win_addr  <= win_addr + width_qa;
                           wr_addr_q <= wr_addr_q + width_qa;
                        end
                        DIR_LEFT: begin
                           cx        <= cx - ONE_D;
                           win_addr  <= win_addr - ONE_A;
                           wr_addr_q <= wr_addr_q - ONE_A;
                        end
                        default: begin
                           cx        <= cx + ONE_D;
                           win_addr  <= win_addr + ONE_A;
                           wr_addr_q <= wr_addr_q + ONE_A;
                        end
                     endcase
                  end else begin
                     row_i     <= row_i + ONE_C;
                     rd_addr_q <= rd_addr_q + ((dir_q == DIR_DOWN) ? ONE_A : width_qa);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
